// File: rtl/icache_op_sched.sv
// Instruction-cache request port scheduler: fetch pass-through, CACOP sequencing
// and full-cache IDXINV walk for IBAR/init, arbitrated CACOP > IBAR > fetch.
module icache_op_sched #(
  parameter int unsigned SET_NUM = 64,
  parameter int unsigned OFF_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [11:0] fetch_idx,
  input  logic [31:0] fetch_pa,
  input  logic        fetch_is_cached,
  output logic        fetch_stall,
  input  logic        cacop_req,
  input  logic [2:0]  cacop_op,
  input  logic [11:0] cacop_idx,
  input  logic [31:0] cacop_pa,
  output logic        cacop_ready,
  output logic        cacop_done,
  input  logic        ibar_req,
  output logic        ibar_ready,
  output logic        ibar_done,
  output logic [2:0]  icache_op,
  output logic [11:0] icache_idx,
  output logic [31:0] icache_pa,
  output logic        icache_is_cached,
  input  logic        icache_busy
);

  localparam int unsigned CNT_W = $clog2(SET_NUM);

  localparam logic [2:0] IC_NOP    = 3'd0;
  localparam logic [2:0] IC_R      = 3'd1;
  localparam logic [2:0] IC_IDXINV = 3'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SET_NUM - 1);

  typedef enum logic [1:0] {IDLE, CWAIT, WALK, WWAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [11:0]      walk_idx;

  // Set index placed above the line offset; upper index bits stay zero.
  assign walk_idx = 12'(cnt) << OFF_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    fetch_stall      = 1'b0;
    cacop_ready      = 1'b0;
    cacop_done       = 1'b0;
    ibar_ready       = 1'b0;
    ibar_done        = 1'b0;
    icache_op        = IC_NOP;
    icache_idx       = '0;
    icache_pa        = '0;
    icache_is_cached = 1'b0;

    unique case (state)
      IDLE: begin
        if (cacop_req) begin
          fetch_stall = 1'b1;
          if (!icache_busy) begin
            icache_op        = cacop_op;
            icache_idx       = cacop_idx;
            icache_pa        = cacop_pa;
            icache_is_cached = 1'b1;
            cacop_ready      = 1'b1;
            state_nxt        = CWAIT;
          end
        end else if (ibar_req) begin
          // Acceptance cycle issues nothing; the first IDXINV goes out next cycle.
          fetch_stall = 1'b1;
          if (!icache_busy) begin
            ibar_ready = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = WALK;
          end
        end else begin
          icache_op        = fetch_req ? IC_R : IC_NOP;
          icache_idx       = fetch_idx;
          icache_pa        = fetch_pa;
          icache_is_cached = fetch_is_cached;
        end
      end
      CWAIT: begin
        fetch_stall = 1'b1;
        if (!icache_busy) begin
          cacop_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WALK: begin
        fetch_stall = 1'b1;
        if (!icache_busy) begin
          icache_op        = IC_IDXINV;
          icache_idx       = walk_idx;
          icache_is_cached = 1'b1;
          if (cnt == CNT_LAST) state_nxt = WWAIT;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      WWAIT: begin
        fetch_stall = 1'b1;
        if (!icache_busy) begin
          ibar_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_op_sched.sv
// Self-checking bench for icache_op_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_icache_op_sched;

  localparam int unsigned SET_NUM = 64;
  localparam int unsigned OFF_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [11:0] fetch_idx;
  logic [31:0] fetch_pa;
  logic        fetch_is_cached;
  logic        fetch_stall;
  logic        cacop_req;
  logic [2:0]  cacop_op;
  logic [11:0] cacop_idx;
  logic [31:0] cacop_pa;
  logic        cacop_ready;
  logic        cacop_done;
  logic        ibar_req;
  logic        ibar_ready;
  logic        ibar_done;
  logic [2:0]  icache_op;
  logic [11:0] icache_idx;
  logic [31:0] icache_pa;
  logic        icache_is_cached;
  logic        icache_busy;

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit last_cready = 1'b0;

  icache_op_sched #(.SET_NUM(SET_NUM), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_idx(fetch_idx), .fetch_pa(fetch_pa),
    .fetch_is_cached(fetch_is_cached), .fetch_stall(fetch_stall),
    .cacop_req(cacop_req), .cacop_op(cacop_op), .cacop_idx(cacop_idx),
    .cacop_pa(cacop_pa), .cacop_ready(cacop_ready), .cacop_done(cacop_done),
    .ibar_req(ibar_req), .ibar_ready(ibar_ready), .ibar_done(ibar_done),
    .icache_op(icache_op), .icache_idx(icache_idx), .icache_pa(icache_pa),
    .icache_is_cached(icache_is_cached), .icache_busy(icache_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: outstanding CACOP flag, and number of sets already
  // invalidated by the current walk (-1 when no walk is in progress).
  bit m_cout = 1'b0;
  int m_sets = -1;

  always @(negedge clk) begin
    logic [2:0]  e_op;
    logic [11:0] e_idx;
    logic [31:0] e_pa;
    logic        e_cached, e_stall, e_cr, e_cd, e_ir, e_id;
    e_op = 3'd0; e_idx = '0; e_pa = '0; e_cached = 1'b0;
    e_stall = 1'b1; e_cr = 1'b0; e_cd = 1'b0; e_ir = 1'b0; e_id = 1'b0;
    if (m_cout) begin
      e_cd = !icache_busy;
    end else if (m_sets >= 0) begin
      if (m_sets < SET_NUM) begin
        if (!icache_busy) begin
          e_op = 3'd3; e_idx = 12'(m_sets * (1 << OFF_W)); e_cached = 1'b1;
        end
      end else begin
        e_id = !icache_busy;
      end
    end else if (cacop_req) begin
      if (!icache_busy) begin
        e_op = cacop_op; e_idx = cacop_idx; e_pa = cacop_pa; e_cached = 1'b1; e_cr = 1'b1;
      end
    end else if (ibar_req) begin
      e_ir = !icache_busy;
    end else begin
      e_stall = 1'b0;
      e_op = fetch_req ? 3'd1 : 3'd0;
      e_idx = fetch_idx; e_pa = fetch_pa; e_cached = fetch_is_cached;
    end

    if (chk_en) begin
      chk("m_op", 32'(icache_op), 32'(e_op));
      chk("m_stall", 32'(fetch_stall), 32'(e_stall));
      chk("m_cready", 32'(cacop_ready), 32'(e_cr));
      chk("m_cdone", 32'(cacop_done), 32'(e_cd));
      chk("m_iready", 32'(ibar_ready), 32'(e_ir));
      chk("m_idone", 32'(ibar_done), 32'(e_id));
      if (e_op != 3'd0) begin
        chk("m_idx", 32'(icache_idx), 32'(e_idx));
        chk("m_pa", icache_pa, e_pa);
        chk("m_cached", 32'(icache_is_cached), 32'(e_cached));
      end
    end
    last_cready = cacop_ready;

    if (rst) begin
      m_cout = 1'b0; m_sets = -1;
    end else if (m_cout) begin
      if (!icache_busy) m_cout = 1'b0;
    end else if (m_sets >= 0) begin
      if (!icache_busy) m_sets = (m_sets < SET_NUM) ? m_sets + 1 : -1;
    end else if (cacop_req) begin
      if (!icache_busy) m_cout = 1'b1;
    end else if (ibar_req && !icache_busy) begin
      m_sets = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  set_no;
    bit  seen;
    rst = 1'b1; fetch_req = 1'b0; fetch_idx = '0; fetch_pa = '0; fetch_is_cached = 1'b0;
    cacop_req = 1'b0; cacop_op = 3'd0; cacop_idx = '0; cacop_pa = '0;
    ibar_req = 1'b0; icache_busy = 1'b0;
    tick();
    chk_en = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("rst_op", 32'(icache_op), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_flags", 32'({cacop_ready, cacop_done, ibar_ready, ibar_done}), 32'd0);

    // Idle pass-through
    tick(); fetch_req = 1'b1; fetch_idx = 12'h123; fetch_pa = 32'h1c000123; fetch_is_cached = 1'b1;
    @(negedge clk);
    chk("pt_op", 32'(icache_op), 32'd1);
    chk("pt_idx", 32'(icache_idx), 32'h123);
    chk("pt_pa", icache_pa, 32'h1c000123);
    chk("pt_stall", 32'(fetch_stall), 32'd0);

    // CACOP with icache idle
    tick(); cacop_req = 1'b1; cacop_op = 3'd4; cacop_idx = 12'h040; cacop_pa = 32'h1c000040;
    @(negedge clk);
    chk("c_op", 32'(icache_op), 32'd4);
    chk("c_ready", 32'(cacop_ready), 32'd1);
    chk("c_stall", 32'(fetch_stall), 32'd1);
    chk("c_pa", icache_pa, 32'h1c000040);
    tick(); cacop_req = 1'b0;
    @(negedge clk);
    chk("c_wait_op", 32'(icache_op), 32'd0);
    chk("c_done", 32'(cacop_done), 32'd1);
    tick();
    @(negedge clk);
    chk("c_after_op", 32'(icache_op), 32'd1);
    chk("c_after_done", 32'(cacop_done), 32'd0);

    // CACOP blocked by busy T..T+2, then busy in CWAIT at T+4
    tick(); icache_busy = 1'b1; cacop_req = 1'b1; cacop_op = 3'd3; cacop_idx = 12'h080; cacop_pa = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cb_ready_lo", 32'(cacop_ready), 32'd0);
      chk("cb_stall", 32'(fetch_stall), 32'd1);
      if (k < 2) tick();
    end
    tick(); icache_busy = 1'b0;
    @(negedge clk);
    chk("cb_ready_t3", 32'(cacop_ready), 32'd1);
    tick(); icache_busy = 1'b1; cacop_req = 1'b0;
    @(negedge clk);
    chk("cb_done_t4", 32'(cacop_done), 32'd0);
    tick(); icache_busy = 1'b0;
    @(negedge clk);
    chk("cb_done_t5", 32'(cacop_done), 32'd1);
    tick();

    // Full walk with one busy cycle at T+10
    ibar_req = 1'b1;
    @(negedge clk);
    chk("w_ready", 32'(ibar_ready), 32'd1);
    chk("w_op_t0", 32'(icache_op), 32'd0);
    for (int k = 1; k <= 66; k++) begin
      tick(); ibar_req = 1'b0; icache_busy = (k == 10);
      @(negedge clk);
      chk("w_stall", 32'(fetch_stall), 32'd1);
      if (k == 66) begin
        chk("w_done", 32'(ibar_done), 32'd1);
      end else if (k == 10) begin
        chk("w_busy_op", 32'(icache_op), 32'd0);
      end else begin
        set_no = (k < 10) ? k - 1 : k - 2;
        chk("w_op", 32'(icache_op), 32'd3);
        chk("w_idx", 32'(icache_idx), 32'(set_no * 64));
        chk("w_done_lo", 32'(ibar_done), 32'd0);
      end
    end
    tick(); icache_busy = 1'b0;
    @(negedge clk);
    chk("w_after_op", 32'(icache_op), 32'd1);

    // Simultaneous CACOP and IBAR
    tick(); cacop_req = 1'b1; cacop_op = 3'd2; cacop_idx = 12'h0c0; ibar_req = 1'b1;
    @(negedge clk);
    chk("s_cready", 32'(cacop_ready), 32'd1);
    chk("s_iready_t0", 32'(ibar_ready), 32'd0);
    chk("s_op", 32'(icache_op), 32'd2);
    tick(); cacop_req = 1'b0;
    @(negedge clk);
    chk("s_cdone", 32'(cacop_done), 32'd1);
    chk("s_iready_t1", 32'(ibar_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("s_iready_t2", 32'(ibar_ready), 32'd1);
    tick(); ibar_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (ibar_done) seen = 1'b1;
      tick();
    end
    chk("s_walk_done_seen", 32'(seen), 32'd1);

    // Reset in the middle of a walk
    ibar_req = 1'b1;
    @(negedge clk);
    chk("r_iready", 32'(ibar_ready), 32'd1);
    for (int k = 1; k < 20; k++) begin
      tick(); ibar_req = 1'b0;
    end
    tick(); rst = 1'b1;
    @(negedge clk);
    tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("r_op", 32'(icache_op), 32'd1);
      chk("r_stall", 32'(fetch_stall), 32'd0);
      chk("r_no_done", 32'(ibar_done), 32'd0);
      tick();
    end
    ibar_req = 1'b1;
    @(negedge clk);
    chk("r2_iready", 32'(ibar_ready), 32'd1);
    tick(); ibar_req = 1'b0;
    @(negedge clk);
    chk("r2_first_idx", 32'(icache_idx), 32'd0);
    chk("r2_first_op", 32'(icache_op), 32'd3);

    // Randomized traffic; requesters hold until accepted
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = ($urandom_range(399) == 0);
      icache_busy = ($urandom_range(3) == 0);
      fetch_req = $urandom_range(1);
      fetch_idx = 12'($urandom);
      fetch_pa = $urandom;
      fetch_is_cached = $urandom_range(1);
      if (cacop_req && last_cready) begin
        cacop_req = 1'b0;
      end else if (!cacop_req && $urandom_range(24) == 0) begin
        cacop_req = 1'b1;
        cacop_op = 3'($urandom_range(4, 2));
        cacop_idx = 12'($urandom);
        cacop_pa = $urandom;
      end
      if (ibar_req && ibar_ready) ibar_req = 1'b0;
      else if (!ibar_req && $urandom_range(39) == 0) ibar_req = 1'b1;
    end
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/icache_op_sched.md
# icache_op_sched

Single-owner scheduler for the instruction-cache request port. It sits between fetch1, the mem1 CACOP path and the IBAR/init path, and arbitrates among them. Fetch reads pass straight through when the scheduler is idle. A CACOP op or a full-cache invalidate walk takes the port, stalls fetch, and sequences the ops against `icache_busy` until they complete.

## Interface
- `SET_NUM`, 64: icache sets; walk count; power of two.
- `OFF_W`, 6: line offset bits; set index = idx[OFF_W +: log2(SET_NUM)].
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_req` in 1: fetch1 wants an IC_R this cycle.
- `fetch_idx` in 12: fetch virtual index.
- `fetch_pa` in 32: fetch physical address.
- `fetch_is_cached` in 1: fetch MAT cached bit.
- `fetch_stall` out 1: scheduler owns the port; fetch1 must hold its PC.
- `cacop_req` in 1: mem1 CACOP request; held until `cacop_ready`.
- `cacop_op` in 3: IC_INIT, IC_IDXINV or IC_HITINV.
- `cacop_idx` in 12: CACOP index.
- `cacop_pa` in 32: CACOP physical address (HITINV tag).
- `cacop_ready` out 1: CACOP accepted (issued) this cycle.
- `cacop_done` out 1: one-cycle pulse, CACOP complete.
- `ibar_req` in 1: invalidate-all request; held until `ibar_ready`.
- `ibar_ready` out 1: walk accepted this cycle.
- `ibar_done` out 1: one-cycle pulse, walk complete.
- `icache_op` out 3: IC_NOP=0, IC_R=1, IC_INIT=2, IC_IDXINV=3, IC_HITINV=4.
- `icache_idx` out 12: op index.
- `icache_pa` out 32: op physical address.
- `icache_is_cached` out 1: op cached bit.
- `icache_busy` in 1: icache cannot accept a new op this cycle.

## Operation
- States: IDLE, CWAIT, WALK, WWAIT. Walk counter `cnt` is log2(SET_NUM) bits.
- IDLE:
  - Default is pass-through: `icache_op` = fetch_req ? IC_R : IC_NOP; idx, pa and is_cached come from fetch; `fetch_stall`=0.
  - Fetch1 handles `icache_busy` stalls itself.
- Priority in IDLE is CACOP > IBAR > fetch.
- CACOP acceptance: in IDLE with cacop_req and !icache_busy:
  - drive cacop_op, cacop_idx, cacop_pa, is_cached=1;
  - `cacop_ready`=1, `fetch_stall`=1, fetch op dropped;
  - next state CWAIT.
- CACOP stall: cacop_req in IDLE with icache_busy gives NOP, ready=0, `fetch_stall`=1.
- CWAIT:
  - Drive IC_NOP; `fetch_stall`=1.
  - On the first cycle with !icache_busy: `cacop_done`=1, next state IDLE.
- IBAR acceptance: in IDLE with ibar_req, no cacop_req and !icache_busy:
  - `ibar_ready`=1 and `fetch_stall`=1; no op is issued this cycle;
  - cnt ← 0; next state WALK.
- WALK, each cycle with !icache_busy:
  - Issue IC_IDXINV with idx = cnt << OFF_W (upper bits 0), pa=0, is_cached=1.
  - If cnt==SET_NUM-1, next state WWAIT; otherwise cnt++.
  - A busy cycle issues NOP and holds cnt.
  - `fetch_stall`=1 throughout.
- WWAIT:
  - Drive NOP; `fetch_stall`=1.
  - On the first !icache_busy cycle: `ibar_done`=1, next state IDLE.
- Requests arriving in any non-IDLE state are ignored until IDLE; ready stays 0.
- IDXINV at a set invalidates all ways of that set.

## Timing
- Reset values:
  - state IDLE, cnt 0;
  - `cacop_ready`, `cacop_done`, `ibar_ready`, `ibar_done`, `fetch_stall` all 0;
  - `icache_op` tracks fetch_req; it is IC_NOP when fetch_req=0.
- All outputs are combinational from state, cnt and inputs; state and cnt are registered.
- CACOP latency with the icache never busy: ready at T, done at T+1. Each busy cycle in CWAIT adds 1.
- Walk latency with the icache never busy: ready at T, IDXINV issues T+1..T+SET_NUM, `ibar_done` at T+SET_NUM+1.
- `cacop_done` and `ibar_done` last exactly one cycle. Fetch may issue IC_R in the cycle after done.
- cnt does not wrap: the exit to WWAIT happens on the issue at SET_NUM-1.
- Reset mid-CACOP or mid-walk: state IDLE and cnt 0 on the next cycle; no done pulse; the requester must reissue.
- Simultaneous cacop_req and ibar_req: CACOP first. IBAR is accepted the cycle after `cacop_done` if still held.

## Test plan
- Idle passthrough: fetch_req=1, idx=0x123, pa=0x1c000123 → `icache_op`=IC_R with the same idx and pa; `fetch_stall`=0. With fetch_req=0 → IC_NOP.
- CACOP, icache not busy: cacop_req with IC_HITINV and pa=0x1c000040 at T → op=4, ready=1, stall=1 at T; NOP at T+1 with `cacop_done`=1; IC_R passthrough at T+2.
- CACOP blocked by busy: busy high T..T+2, cacop_req from T → ready first at T+3; busy high at T+4 → `cacop_done` at T+5.
- IBAR walk, SET_NUM=64: ready at T; IDXINV idx 0x000, 0x040, …, 0xFC0 at T+1..T+64; `ibar_done` at T+65; `fetch_stall`=1 on T..T+65. Inject busy at T+10 → idx 0x240 is held one extra cycle and done shifts to T+66.
- Simultaneous cacop_req and ibar_req at T → CACOP issued at T, done at T+1, `ibar_ready` at T+2.
- Reset at walk cycle T+20 → IDLE next cycle, no `ibar_done`, passthrough resumes; cnt restarts at 0 on the next IBAR.
